// File: rtl/uart_cpu_port.sv
// uart_cpu_port: memory-mapped UART transmit port for the 6502 bus.
// CPU writes are queued in a circular FIFO. A drain FSM presents one byte at a
// time to uart_buffer, holding data_strobe for two baud_x1 ticks and then
// leaving two ticks of gap, so the buffer captures every byte exactly once.
//
// Optional feature macro: UART_CPU_PORT_HEX_EN (offset-1 writes push the byte
// as two uppercase ASCII hex characters).
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   baud_x1        one-cycle tick shared with uart_buffer
//   addr, wdata    CPU address / write data
//   we, re         CPU write / read enables
//   rdata          registered read data (1-cycle latency, held when re is low)
//   tx_data        byte to uart_buffer.data
//   tx_strobe      to uart_buffer.data_strobe
module uart_cpu_port #(
   parameter logic [15:0] BASE_ADDR  = 16'h4000,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        baud_x1,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        we,
   input  logic        re,
   output logic [7:0]  rdata,
   output logic [7:0]  tx_data,
   output logic        tx_strobe
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic                  ovf;

   state_t state;
   state_t state_nx;
   logic   tick_seen;
   logic   tick_seen_nx;
   logic   strobe_nx;
   logic   pop;

   logic       sel;
   logic       wr0;
   logic       rd0;
   logic       fifo_full;
   logic       fifo_empty;
   logic       status_full;
   logic       push_req;
   logic       push_ok;
   logic       cpu_drop;
   logic       ovf_set;
   logic [7:0] push_data;

   // Register window decode
   assign sel = (addr[15:2] == BASE_ADDR[15:2]);
   assign wr0 = we & sel & (addr[1:0] == 2'd0);
   assign rd0 = re & sel & (addr[1:0] == 2'd0);

   assign fifo_full  = (count == CW'(DEPTH));
   assign fifo_empty = (count == '0);

`ifdef UART_CPU_PORT_HEX_EN
   logic       wr1;
   logic       pend;
   logic [7:0] pend_char;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
   endfunction

   assign wr1 = we & sel & (addr[1:0] == 2'd1);

   // Pending low-nibble character owns the push slot; CPU pushes meanwhile are lost
   always_comb begin
      push_req  = 1'b0;
      push_data = wdata;
      cpu_drop  = 1'b0;
      if (pend) begin
         push_req  = 1'b1;
         push_data = pend_char;
         cpu_drop  = wr0 | wr1;
      end else if (wr1) begin
         push_req  = 1'b1;
         push_data = hex_char(wdata[7:4]);
      end else if (wr0) begin
         push_req  = 1'b1;
      end
   end

   assign status_full = fifo_full | pend;

   // Pending lasts exactly one cycle: it is consumed (pushed or dropped) next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         pend      <= 1'b0;
         pend_char <= 8'h00;
      end else if (pend) begin
         pend      <= 1'b0;
      end else if (wr1) begin
         pend      <= 1'b1;
         pend_char <= hex_char(wdata[3:0]);
      end
   end
`else
   assign push_req    = wr0;
   assign push_data   = wdata;
   assign cpu_drop    = 1'b0;
   assign status_full = fifo_full;
`endif

   // Full check uses pre-cycle count, so a same-cycle pop never rescues a push into a full FIFO
   assign push_ok = push_req & ~fifo_full;
   assign ovf_set = (push_req & fifo_full) | cpu_drop;

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // FIFO pointers, occupancy and sticky overflow (set beats clear-on-read)
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop);
         if (ovf_set)  ovf <= 1'b1;
         else if (rd0) ovf <= 1'b0;
      end
   end

   // Drain FSM next-state: two ticks with strobe high, then two ticks of gap
   always_comb begin
      state_nx     = state;
      tick_seen_nx = tick_seen;
      strobe_nx    = tx_strobe;
      pop          = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop          = 1'b1;
               strobe_nx    = 1'b1;
               tick_seen_nx = 1'b0;
               state_nx     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (baud_x1) begin
               if (tick_seen) begin
                  tick_seen_nx = 1'b0;
                  strobe_nx    = 1'b0;
                  state_nx     = ST_GAP;
               end else begin
                  tick_seen_nx = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (baud_x1) begin
               if (tick_seen) begin
                  tick_seen_nx = 1'b0;
                  state_nx     = ST_IDLE;
               end else begin
                  tick_seen_nx = 1'b1;
               end
            end
         end
         default: begin
            state_nx     = ST_IDLE;
            tick_seen_nx = 1'b0;
            strobe_nx    = 1'b0;
         end
      endcase
   end

   // Drain FSM state and transmit outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         tick_seen <= 1'b0;
         tx_strobe <= 1'b0;
         tx_data   <= 8'h00;
      end else begin
         state     <= state_nx;
         tick_seen <= tick_seen_nx;
         tx_strobe <= strobe_nx;
         if (pop) tx_data <= mem[rd_ptr];
      end
   end

   // Register reads; values reflect state before this cycle's updates
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= 8'h00;
      end else if (re) begin
         rdata <= 8'h00;
         if (sel) begin
            case (addr[1:0])
               2'd0:    rdata <= {5'b0, ovf, status_full, fifo_empty};
               2'd1:    rdata <= 8'(count);
               default: rdata <= 8'h00;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cpu_port.sv
// Scoreboard bench for uart_cpu_port: stimulus pushes expected read data and
// expected transmit bytes into queues; a monitor pops and compares them when
// the DUT presents read data or raises tx_strobe.
module tb_uart_cpu_port;

   localparam logic [15:0] BASE = 16'h4000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        baud_x1 = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  wdata = 8'h00;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [7:0]  rdata;
   logic [7:0]  tx_data;
   logic        tx_strobe;

   int checks = 0;
   int errors = 0;

   logic [7:0] rd_q[$];
   logic [7:0] tx_q[$];
   logic       baud_en = 1'b0;
   logic       re_d = 1'b0;

   uart_cpu_port #(.BASE_ADDR(BASE), .DEPTH_LOG2(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .baud_x1   (baud_x1),
      .addr      (addr),
      .wdata     (wdata),
      .we        (we),
      .re        (re),
      .rdata     (rdata),
      .tx_data   (tx_data),
      .tx_strobe (tx_strobe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) re_d <= re;

   // baud_x1: one-cycle tick every 4 clocks while enabled
   initial begin : baud_gen
      logic [1:0] div;
      div = 2'd0;
      forever begin
         @(posedge clk);
         #1;
         div = div + 2'd1;
         baud_x1 = baud_en && (div == 2'd3);
      end
   end

   // Monitor: read data, transmitted bytes, hold/gap tick counts
   initial begin : monitor
      logic [7:0] exp;
      logic prev, abort, fall_seen;
      int hi, lo;
      prev = 1'b0; abort = 1'b0; fall_seen = 1'b0; hi = 0; lo = 0;
      forever begin
         @(negedge clk);
         if (re_d) begin
            checks++;
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected: rdata=%02h with no read pending", rdata);
            end else begin
               exp = rd_q.pop_front();
               if (rdata !== exp) begin
                  errors++;
                  $display("FAIL rdata: got %02h expected %02h", rdata, exp);
               end
            end
         end
         if (tx_strobe && !prev) begin
            checks++;
            if (tx_q.size() == 0) begin
               errors++;
               $display("FAIL tx_unexpected: strobe with tx_data=%02h, nothing queued", tx_data);
            end else begin
               exp = tx_q.pop_front();
               if (tx_data !== exp) begin
                  errors++;
                  $display("FAIL tx_data: got %02h expected %02h", tx_data, exp);
               end
            end
            if (fall_seen) begin
               checks++;
               if (lo < 2) begin
                  errors++;
                  $display("FAIL gap_ticks: got %0d expected at least 2", lo);
               end
            end
            hi = 0;
            abort = 1'b0;
         end
         if (!tx_strobe && prev) begin
            if (!abort) begin
               checks++;
               if (hi != 2) begin
                  errors++;
                  $display("FAIL hold_ticks: got %0d expected 2", hi);
               end
            end
            fall_seen = !abort;
            lo = 0;
         end
         if (baud_x1) begin
            if (tx_strobe) hi++;
            else lo++;
         end
         if (reset) begin
            abort = 1'b1;
            fall_seen = 1'b0;
         end
         prev = tx_strobe;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic cyc_idle();
      @(posedge clk);
      #1;
      we = 1'b0;
      re = 1'b0;
   endtask

   task automatic idle_n(input int n);
      repeat (n) cyc_idle();
   endtask

   task automatic cyc_write(input logic [15:0] a, input logic [7:0] d, input logic expect_tx);
      @(posedge clk);
      #1;
      addr = a; wdata = d; we = 1'b1; re = 1'b0;
      if (expect_tx) tx_q.push_back(d);
   endtask

   task automatic cyc_read(input logic [15:0] a, input logic [7:0] e);
      @(posedge clk);
      #1;
      addr = a; we = 1'b0; re = 1'b1;
      rd_q.push_back(e);
   endtask

   task automatic cyc_wr_rd(input logic [15:0] a, input logic [7:0] d, input logic [7:0] e);
      @(posedge clk);
      #1;
      addr = a; wdata = d; we = 1'b1; re = 1'b1;
      rd_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((tx_q.size() != 0 || tx_strobe) && n < budget) begin
         cyc_idle();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d bytes outstanding after %0d cycles", tx_q.size(), budget);
      end
      idle_n(40);
   endtask

   initial begin
      // Reset state
      idle_n(3);
      @(negedge clk);
      chk("reset_strobe", 8'(tx_strobe), 8'h00);
      chk("reset_tx_data", tx_data, 8'h00);
      chk("reset_rdata", rdata, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc_read(BASE, 8'h01);
      cyc_read(BASE + 16'd1, 8'h00);
      cyc_idle();

      // Single byte: strobe rises two cycles after the write
      baud_en = 1'b1;
      cyc_write(BASE, 8'h41, 1'b1);
      cyc_idle();
      @(negedge clk);
      chk("latency_n1_strobe", 8'(tx_strobe), 8'h00);
      @(negedge clk);
      chk("latency_n2_strobe", 8'(tx_strobe), 8'h01);
      chk("latency_n2_data", tx_data, 8'h41);
      wait_drain(500);
      cyc_read(BASE + 16'd1, 8'h00);
      cyc_read(BASE, 8'h01);
      cyc_idle();

      // Fill with baud stalled: byte 00 is popped into HOLD, 01..10 fill 16 entries
      baud_en = 1'b0;
      cyc_idle();
      for (int i = 0; i < 17; i++) cyc_write(BASE, 8'(i), 1'b1);
      cyc_read(BASE, 8'h02);
      cyc_write(BASE, 8'h11, 1'b0);
      cyc_read(BASE, 8'h06);
      cyc_read(BASE, 8'h02);
      cyc_wr_rd(BASE, 8'h12, 8'h02);
      cyc_read(BASE, 8'h06);
      cyc_read(BASE + 16'd1, 8'h10);
      cyc_idle();
      baud_en = 1'b1;
      wait_drain(2000);
      cyc_read(BASE + 16'd1, 8'h00);
      cyc_read(BASE, 8'h01);
      cyc_idle();

      // Reset while in HOLD with three bytes queued
      baud_en = 1'b0;
      cyc_idle();
      cyc_write(BASE, 8'hAA, 1'b1);
      cyc_write(BASE, 8'hBB, 1'b0);
      cyc_write(BASE, 8'hCC, 1'b0);
      cyc_write(BASE, 8'hDD, 1'b0);
      cyc_idle();
      cyc_read(BASE + 16'd1, 8'h03);
      cyc_idle();
      @(negedge clk);
      chk("hold_before_reset", 8'(tx_strobe), 8'h01);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("strobe_after_reset", 8'(tx_strobe), 8'h00);
      baud_en = 1'b1;
      idle_n(60);
      cyc_read(BASE + 16'd1, 8'h00);
      cyc_read(BASE, 8'h01);
      cyc_idle();

`ifdef UART_CPU_PORT_HEX_EN
      // Hex push of A7 emits 'A' then '7'; CPU push during pending is dropped
      cyc_write(BASE + 16'd1, 8'hA7, 1'b0);
      tx_q.push_back(8'h41);
      tx_q.push_back(8'h37);
      cyc_wr_rd(BASE, 8'h55, 8'h02);
      cyc_read(BASE, 8'h04);
      cyc_idle();
      wait_drain(500);
      cyc_read(BASE, 8'h01);
      cyc_idle();
`else
      // Offset-1 write has no effect without the hex feature
      cyc_write(BASE + 16'd1, 8'hA7, 1'b0);
      cyc_idle();
      cyc_read(BASE + 16'd1, 8'h00);
      cyc_read(BASE, 8'h01);
      cyc_idle();
      idle_n(30);
`endif

      // rdata holds with re low; unmapped offsets and out-of-window accesses
      cyc_read(BASE, 8'h01);
      idle_n(3);
      @(negedge clk);
      chk("rdata_hold", rdata, 8'h01);
      cyc_write(BASE + 16'd2, 8'h5A, 1'b0);
      cyc_write(BASE + 16'd3, 8'h5B, 1'b0);
      cyc_write(BASE + 16'd4, 8'h5C, 1'b0);
      cyc_write(16'h3FFC, 8'h5D, 1'b0);
      cyc_idle();
      cyc_read(BASE + 16'd2, 8'h00);
      cyc_read(BASE, 8'h01);
      cyc_read(BASE + 16'd3, 8'h00);
      cyc_read(BASE + 16'd4, 8'h00);
      cyc_read(BASE + 16'd1, 8'h00);
      cyc_idle();
      idle_n(30);

      checks++;
      if (rd_q.size() != 0 || tx_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d reads and %0d bytes still expected, required 0", rd_q.size(), tx_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
